// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
//
// Shared definitions for the two-master SDRAM arbiter slice.
//
// Contents:
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF - default port widths. These match the
//                                     SDRAM controller instantiation.
//   STREAK_WIDTH                    - width of the m0 streak counter. It covers
//                                     the whole legal M0_MAX_STREAK range
//                                     (1..255).
//   ST_IDLE / ST_ISSUE / ST_RDWAIT  - arbiter FSM state encoding.
//   OWN_M0 / OWN_M1                 - encoding of the master that owns the
//                                     command in flight.
//   streak_inc()                    - saturating increment for the streak
//                                     counter.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 23;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    localparam int unsigned STREAK_WIDTH = 8;
    typedef logic [STREAK_WIDTH-1:0] streak_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    // Saturating increment. The counter never reaches a value above max.
    function automatic streak_t streak_inc(input streak_t cur, input streak_t max);
        return (cur >= max) ? max : cur + streak_t'(1);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
//
// One request port of the SDRAM request protocol (req/ack/valid handshake).
// The same interface type is used three times:
//   - the display prefetcher port (m0, read-only: we and data are ignored);
//   - the general read/write port (m1);
//   - the port toward the SDRAM controller (mem).
//
// Signals:
//   req   - command request, held until ack
//   we    - 1 = write, 0 = read
//   addr  - word address
//   data  - write data
//   ack   - one-cycle accept pulse
//   valid - one-cycle read-data pulse
//   q     - read data
//
// Modports:
//   master - issues commands (drives req/we/addr/data, receives ack/valid/q)
//   slave  - serves commands (the opposite direction)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  ack;
    logic                  valid;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output req,
        output we,
        output addr,
        output data,
        input  ack,
        input  valid,
        input  q
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  data,
        output ack,
        output valid,
        output q
    );

endinterface

// File: rtl/sdram_arb_watchdog.sv
// -----------------------------------------------------------------------------
// sdram_arb_watchdog
//
// A loadable down-counter with an expiry indication. It is used to bound the
// time the arbiter waits for read data.
//
// Ports:
//   clk      in  - clock
//   rst      in  - synchronous active-high reset (the count goes to 0)
//   load     in  - load load_val. Load takes priority over counting.
//   en       in  - count down while high. The counter stops at zero.
//   load_val in  - reload value. Expiry happens on the (load_val+1)-th enabled
//                  cycle after the load.
//   expired  out - high in an enabled cycle where the count has reached zero
// -----------------------------------------------------------------------------
module sdram_arb_watchdog #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = en && (count_q == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single SDRAM controller request port between two masters. Only
// one command is in flight at a time.
//   m0 - the display line prefetcher. It is read-only and has high priority.
//   m1 - the general read/write port (font and framebuffer updates). It is
//        forced in after M0_MAX_STREAK back-to-back m0 grants.
//
// Ports:
//   sys_clk     in  - system clock (48 MHz)
//   rst         in  - synchronous, active-high reset
//   m0          slave  - prefetcher port (we/data ignored, always reads)
//   m1          slave  - general read/write port
//   mem         master - SDRAM controller port
//   busy        out - high whenever the FSM is not in IDLE
//   timeout_err out - sticky read-timeout abort flag (cleared by rst only)
//
// Acks and read-valids toward the masters are combinational from mem ack/valid.
// Read data is passed through unregistered.
//
// Optional feature, macro ARB_TIMEOUT_EN: a watchdog aborts a read that sees
// no mem valid within TIMEOUT_CYCLES cycles in RDWAIT, and sets timeout_err.
// Without the macro, RDWAIT waits indefinitely and timeout_err is tied to 0.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned M0_MAX_STREAK  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            sys_clk,
    input  logic            rst,
    sdram_arbiter_if.slave  m0,
    sdram_arbiter_if.slave  m1,
    sdram_arbiter_if.master mem,
    output logic            busy,
    output logic            timeout_err
);

    localparam streak_t STREAK_MAX = streak_t'(M0_MAX_STREAK);

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    streak_t               streak_q, streak_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic grant_m1;
    logic abort;

    // m0 keeps priority unless it is idle or it has used up its streak.
    assign grant_m1 = !m0.req || (streak_q == STREAK_MAX);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                // The streak only counts while m1 is actually waiting.
                if (!m1.req) begin
                    streak_d = '0;
                end
                if (m0.req || m1.req) begin
                    state_d   = ST_ISSUE;
                    mem_req_d = 1'b1;
                    if (grant_m1) begin
                        owner_d    = OWN_M1;
                        mem_we_d   = m1.we;
                        mem_addr_d = m1.addr;
                        mem_data_d = m1.data;
                        streak_d   = '0;
                    end else begin
                        owner_d    = OWN_M0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = m0.addr;
                        mem_data_d = '0;
                        if (m1.req) begin
                            streak_d = streak_inc(streak_q, STREAK_MAX);
                        end
                    end
                end
            end

            ST_ISSUE: begin
                // A mem valid that coincides with the ack is dropped here.
                if (mem.ack) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? ST_IDLE : ST_RDWAIT;
                end
            end

            ST_RDWAIT: begin
                if (mem.valid || abort) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_M0;
            streak_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WDT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic wdt_load;
    logic wdt_expired;
    logic timeout_err_q;

    // Armed on the ack of a read. It then counts the RDWAIT cycles.
    assign wdt_load = (state_q == ST_ISSUE) && mem.ack && !mem_we_q;

    sdram_arb_watchdog #(
        .WIDTH (WDT_WIDTH)
    ) u_watchdog (
        .clk      (sys_clk),
        .rst      (rst),
        .load     (wdt_load),
        .en       (state_q == ST_RDWAIT),
        .load_val (WDT_WIDTH'(TIMEOUT_CYCLES - 1)),
        .expired  (wdt_expired)
    );

    // If data arrives on the last allowed cycle, it still counts as a success.
    assign abort = wdt_expired && !mem.valid;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else if (abort) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign mem.req  = mem_req_q;
    assign mem.we   = mem_we_q;
    assign mem.addr = mem_addr_q;
    assign mem.data = mem_data_q;

    assign m0.ack   = mem.ack && (state_q == ST_ISSUE) && (owner_q == OWN_M0);
    assign m1.ack   = mem.ack && (state_q == ST_ISSUE) && (owner_q == OWN_M1);
    assign m0.valid = mem.valid && (state_q == ST_RDWAIT) && (owner_q == OWN_M0);
    assign m1.valid = mem.valid && (state_q == ST_RDWAIT) && (owner_q == OWN_M1);
    assign m0.q     = mem.q;
    assign m1.q     = mem.q;

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed bench for sdram_arbiter. A small scripted SDRAM controller model
// answers mem requests with a programmable ack delay and read-data delay.
// Ack, valid and grant events are collected at the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 32;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic busy;
    logic timeout_err;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sdram_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .M0_MAX_STREAK  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem         (mem_if),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Event collection
    int   m0_ack_n = 0;
    int   m1_ack_n = 0;
    int   m0_val_n = 0;
    int   m1_val_n = 0;
    logic grants[$];

    always @(negedge sys_clk) begin
        if (m0_if.ack) begin
            m0_ack_n++;
            grants.push_back(1'b0);
        end
        if (m1_if.ack) begin
            m1_ack_n++;
            grants.push_back(1'b1);
        end
        if (m0_if.valid) m0_val_n++;
        if (m1_if.valid) m1_val_n++;
    end

    // Controller model
    int          ack_dly   = 1;
    int          val_dly   = 1;
    bit          no_data   = 1'b0;
    logic [31:0] rd_data   = 32'h0;
    int          spur_req  = 0;
    int          spur_done = 0;
    int          ctl_st    = 0;
    int          ctl_cnt   = 0;

    initial begin
        mem_if.ack   = 1'b0;
        mem_if.valid = 1'b0;
        mem_if.q     = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            mem_if.ack   = 1'b0;
            mem_if.valid = 1'b0;
            case (ctl_st)
                0: begin
                    if (spur_done != spur_req) begin
                        mem_if.valid = 1'b1;
                        mem_if.q     = 32'h12345678;
                        spur_done    = spur_req;
                    end else if (mem_if.req) begin
                        ctl_cnt = ack_dly;
                        ctl_st  = 1;
                    end
                end
                1: begin
                    ctl_cnt--;
                    if (ctl_cnt <= 0) begin
                        mem_if.ack = 1'b1;
                        if (!mem_if.we && !no_data) begin
                            ctl_cnt = val_dly;
                            ctl_st  = 2;
                        end else begin
                            ctl_st = 0;
                        end
                    end
                end
                2: begin
                    ctl_cnt--;
                    if (ctl_cnt <= 0) begin
                        mem_if.valid = 1'b1;
                        mem_if.q     = rd_data;
                        ctl_st       = 0;
                    end
                end
                default: ctl_st = 0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit expired");
    end

    logic exp_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   b0a, b1a, b0v, b1v;
    int   rd_cycles;

    initial begin
        m0_if.req  = 1'b0;
        m0_if.we   = 1'b0;
        m0_if.addr = '0;
        m0_if.data = '0;
        m1_if.req  = 1'b0;
        m1_if.we   = 1'b0;
        m1_if.addr = '0;
        m1_if.data = '0;

        // Reset state
        rst = 1'b1;
        tick(3);
        @(negedge sys_clk);
        check("rst_mem_req", mem_if.req, 0);
        check("rst_mem_we", mem_if.we, 0);
        check("rst_mem_addr", mem_if.addr, 0);
        check("rst_mem_data", mem_if.data, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // m0 read
        ack_dly = 2;
        val_dly = 3;
        rd_data = 32'hDEADBEEF;
        b0a = m0_ack_n; b1a = m1_ack_n; b0v = m0_val_n; b1v = m1_val_n;
        m0_if.addr = 23'h000040;
        m0_if.req  = 1'b1;
        @(negedge sys_clk);
        check("m0_req_not_yet", mem_if.req, 0);
        @(negedge sys_clk);
        check("m0_mem_req", mem_if.req, 1);
        check("m0_busy", busy, 1);
        check("m0_mem_addr", mem_if.addr, 23'h000040);
        check("m0_mem_we", mem_if.we, 0);
        for (int i = 0; i < 20 && !m0_if.ack; i++) @(negedge sys_clk);
        check("m0_ack_seen", m0_if.ack, 1);
        tick(1);
        m0_if.req = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m0_if.valid; i++) @(negedge sys_clk);
        check("m0_valid_seen", m0_if.valid, 1);
        check("m0_q", m0_if.q, 32'hDEADBEEF);
        check("m0_rd_m1_valid", m1_if.valid, 0);
        tick(3);
        @(negedge sys_clk);
        check("m0_ack_count", m0_ack_n - b0a, 1);
        check("m0_valid_count", m0_val_n - b0v, 1);
        check("m0_rd_m1_valid_count", m1_val_n - b1v, 0);
        check("m0_idle_busy", busy, 0);

        // m1 write
        ack_dly = 1;
        b0a = m0_ack_n; b1a = m1_ack_n; b0v = m0_val_n; b1v = m1_val_n;
        tick(1);
        m1_if.we   = 1'b1;
        m1_if.addr = 23'h55AA55;
        m1_if.data = 32'h55AA55AA;
        m1_if.req  = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m1_if.ack; i++) @(negedge sys_clk);
        check("m1_wr_ack_seen", m1_if.ack, 1);
        check("m1_wr_mem_we", mem_if.we, 1);
        check("m1_wr_mem_addr", mem_if.addr, 23'h55AA55);
        check("m1_wr_mem_data", mem_if.data, 32'h55AA55AA);
        check("m1_wr_m0_ack", m0_if.ack, 0);
        tick(1);
        m1_if.req = 1'b0;
        m1_if.we  = 1'b0;
        @(negedge sys_clk);
        check("m1_wr_busy_fall", busy, 0);
        check("m1_wr_mem_req_low", mem_if.req, 0);
        tick(2);
        @(negedge sys_clk);
        check("m1_wr_ack_count", m1_ack_n - b1a, 1);
        check("m1_wr_no_valid", (m0_val_n - b0v) + (m1_val_n - b1v), 0);

        // Both masters hold requests: streak limit forces m1 in every fifth grant
        ack_dly = 1;
        val_dly = 1;
        rd_data = 32'hA5A5A5A5;
        grants.delete();
        tick(1);
        m0_if.addr = 23'h000100;
        m1_if.addr = 23'h000200;
        m1_if.we   = 1'b0;
        m0_if.req  = 1'b1;
        m1_if.req  = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 400 && grants.size() < 10; i++) @(negedge sys_clk);
        check("streak_grant_count", grants.size() >= 10, 1);
        tick(1);
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
        tick(20);
        @(negedge sys_clk);
        check("streak_busy_end", busy, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("streak_grant%0d", i),
                  (i < grants.size()) ? grants[i] : 1'bx, exp_seq[i]);
        end

        // Reset while in RDWAIT; late data must be dropped
        ack_dly = 1;
        val_dly = 4;
        rd_data = 32'h0BADF00D;
        b0v = m0_val_n; b1v = m1_val_n;
        tick(1);
        m0_if.addr = 23'h000300;
        m0_if.req  = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m0_if.ack; i++) @(negedge sys_clk);
        check("rst_rd_ack_seen", m0_if.ack, 1);
        tick(1);
        m0_if.req = 1'b0;
        rst       = 1'b1;
        @(negedge sys_clk);
        check("rst_rd_busy_before", busy, 1);
        tick(1);
        rst = 1'b0;
        @(negedge sys_clk);
        check("rst_rd_mem_req", mem_if.req, 0);
        check("rst_rd_busy", busy, 0);
        tick(6);
        @(negedge sys_clk);
        check("rst_rd_m0_valid_count", m0_val_n - b0v, 0);
        check("rst_rd_m1_valid_count", m1_val_n - b1v, 0);

        // Spurious mem valid while idle
        b0v = m0_val_n; b1v = m1_val_n;
        tick(1);
        spur_req++;
        tick(3);
        @(negedge sys_clk);
        check("spur_m0_valid_count", m0_val_n - b0v, 0);
        check("spur_m1_valid_count", m1_val_n - b1v, 0);
        check("spur_busy", busy, 0);
        check("spur_mem_req", mem_if.req, 0);

`ifdef ARB_TIMEOUT_EN
        // Read that never returns data: abort after 16 RDWAIT cycles
        no_data = 1'b1;
        ack_dly = 1;
        b0v = m0_val_n;
        tick(1);
        m0_if.addr = 23'h000400;
        m0_if.req  = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m0_if.ack; i++) @(negedge sys_clk);
        check("to_ack_seen", m0_if.ack, 1);
        tick(1);
        m0_if.req = 1'b0;
        rd_cycles = 0;
        @(negedge sys_clk);
        for (int i = 0; i < 40 && busy; i++) begin
            rd_cycles++;
            @(negedge sys_clk);
        end
        check("to_rdwait_cycles", rd_cycles, 16);
        check("to_busy", busy, 0);
        check("to_err_set", timeout_err, 1);
        check("to_m0_valid_count", m0_val_n - b0v, 0);

        // Following m1 read completes normally
        no_data = 1'b0;
        val_dly = 2;
        rd_data = 32'hCAFEF00D;
        tick(1);
        m1_if.we   = 1'b0;
        m1_if.addr = 23'h000123;
        m1_if.req  = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m1_if.ack; i++) @(negedge sys_clk);
        check("to_m1_ack_seen", m1_if.ack, 1);
        tick(1);
        m1_if.req = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 20 && !m1_if.valid; i++) @(negedge sys_clk);
        check("to_m1_valid_seen", m1_if.valid, 1);
        check("to_m1_q", m1_if.q, 32'hCAFEF00D);
        check("to_err_sticky", timeout_err, 1);
`else
        check("timeout_err_off", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
